// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with ready/valid handshake on both sides.
// Define MEM_WB_PIPE_SKID_EN for a registered in_ready backed by a second (skid) entry.
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_memtoreg,
  input  logic              in_regwrite,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [DATA_W-1:0] in_readdata,
  input  logic [DATA_W-1:0] in_aluresult,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_memtoreg,
  output logic              out_regwrite,
  output logic [REG_W-1:0]  out_rd,
  output logic [DATA_W-1:0] out_readdata,
  output logic [DATA_W-1:0] out_aluresult,
  output logic [DATA_W-1:0] out_wdata,
  output logic [1:0]        occupancy
);

  localparam int PAY_W = 2 + REG_W + 2 * DATA_W;

  logic [PAY_W-1:0] w_in_beat;
  logic [PAY_W-1:0] r_out_beat;
  logic             r_out_valid;
  logic             w_regwrite_held;
  logic             w_in_xfer;

  assign w_in_beat = {in_memtoreg, in_regwrite, in_rd, in_readdata, in_aluresult};
  assign w_in_xfer = in_valid && in_ready;

  assign {out_memtoreg, w_regwrite_held, out_rd, out_readdata, out_aluresult} = r_out_beat;
  assign out_valid    = r_out_valid;
  // A stale regwrite bit must never reach the register file.
  assign out_regwrite = r_out_valid && w_regwrite_held;
  assign out_wdata    = out_memtoreg ? out_readdata : out_aluresult;

`ifdef MEM_WB_PIPE_SKID_EN
  logic [PAY_W-1:0] r_skid_beat;
  logic             r_skid_valid;
  logic             w_load_out;

  // in_ready depends only on state, breaking the out_ready -> in_ready path.
  assign in_ready   = !r_skid_valid;
  assign w_load_out = !r_out_valid || out_ready;
  assign occupancy  = {1'b0, r_out_valid} + {1'b0, r_skid_valid};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out_beat   <= '0;
      r_skid_beat  <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_load_out) begin
      if (r_skid_valid) begin
        r_out_beat   <= r_skid_beat;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_in_xfer) begin
        r_out_beat  <= w_in_beat;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_xfer) begin
      // Output stalled: park the new beat behind it.
      r_skid_beat  <= w_in_beat;
      r_skid_valid <= 1'b1;
    end
  end
`else
  logic w_out_xfer;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_out_xfer = r_out_valid && out_ready;
  assign occupancy  = {1'b0, r_out_valid};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_beat  <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_in_xfer) begin
      r_out_beat  <= w_in_beat;
      r_out_valid <= 1'b1;
    end else if (w_out_xfer) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed self-checking bench for mem_wb_pipe; expectations follow the
// MEM_WB_PIPE_SKID_EN setting used to build the design.
module tb_mem_wb_pipe;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              in_memtoreg;
  logic              in_regwrite;
  logic [REG_W-1:0]  in_rd;
  logic [DATA_W-1:0] in_readdata;
  logic [DATA_W-1:0] in_aluresult;
  logic              out_valid;
  logic              out_ready;
  logic              out_memtoreg;
  logic              out_regwrite;
  logic [REG_W-1:0]  out_rd;
  logic [DATA_W-1:0] out_readdata;
  logic [DATA_W-1:0] out_aluresult;
  logic [DATA_W-1:0] out_wdata;
  logic [1:0]        occupancy;

  int n_checks;
  int n_fail;

  mem_wb_pipe #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_memtoreg   (in_memtoreg),
    .in_regwrite   (in_regwrite),
    .in_rd         (in_rd),
    .in_readdata   (in_readdata),
    .in_aluresult  (in_aluresult),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_memtoreg  (out_memtoreg),
    .out_regwrite  (out_regwrite),
    .out_rd        (out_rd),
    .out_readdata  (out_readdata),
    .out_aluresult (out_aluresult),
    .out_wdata     (out_wdata),
    .occupancy     (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic m2r, input logic rw, input logic [REG_W-1:0] rd,
                       input logic [DATA_W-1:0] rdata, input logic [DATA_W-1:0] alu);
    in_valid     = v;
    in_memtoreg  = m2r;
    in_regwrite  = rw;
    in_rd        = rd;
    in_readdata  = rdata;
    in_aluresult = alu;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    flush     = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;

    // Reset held with a beat offered on the input
    drive(1'b1, 1'b1, 1'b1, 5'd9, 32'hFFFF_0000, 32'h0000_FFFF);
    for (int i = 0; i < 3; i++) tick();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_occupancy", occupancy, 0);
    check_eq("rst_regwrite", out_regwrite, 0);
    check_eq("rst_memtoreg", out_memtoreg, 0);
    check_eq("rst_rd", out_rd, 0);
    check_eq("rst_readdata", out_readdata, 0);
    check_eq("rst_aluresult", out_aluresult, 0);
    check_eq("rst_wdata", out_wdata, 0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    #1;
    check_eq("rst_in_ready", in_ready, 1);

    // Streaming: 8 beats, 1-cycle latency, no bubbles
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, REG_W'(i + 1), 32'hAAAA_0000 + 32'(i), 32'h10 + 32'(i));
      #1;
      check_eq("stream_in_ready", in_ready, 1);
      tick();
      check_eq("stream_out_valid", out_valid, 1);
      check_eq("stream_wdata", out_wdata, 32'h10 + 32'(i));
      check_eq("stream_rd", out_rd, 64'(i + 1));
      check_eq("stream_regwrite", out_regwrite, 1);
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    check_eq("stream_drain_valid", out_valid, 0);
    check_eq("stream_drain_regwrite", out_regwrite, 0);
    check_eq("stream_drain_occ", occupancy, 0);

    // Backpressure: rd=3 then rd=4 with output stalled
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 5'd3, 32'h0, 32'h33);
    tick();
    check_eq("bp_first_rd", out_rd, 3);
    check_eq("bp_first_occ", occupancy, 1);
    drive(1'b1, 1'b0, 1'b1, 5'd4, 32'h0, 32'h44);
    #1;
`ifdef MEM_WB_PIPE_SKID_EN
    check_eq("bp_in_ready_skid_free", in_ready, 1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    check_eq("bp_occ_full", occupancy, 2);
    check_eq("bp_in_ready_full", in_ready, 0);
    check_eq("bp_rd_hold", out_rd, 3);
    tick();
    check_eq("bp_rd_stable", out_rd, 3);
    check_eq("bp_wdata_stable", out_wdata, 32'h33);
    check_eq("bp_occ_stable", occupancy, 2);
    out_ready = 1'b1;
    #1;
    check_eq("bp_in_ready_registered", in_ready, 0);
    tick();
    check_eq("bp_second_rd", out_rd, 4);
    check_eq("bp_second_valid", out_valid, 1);
    check_eq("bp_second_occ", occupancy, 1);
    check_eq("bp_in_ready_back", in_ready, 1);
`else
    check_eq("bp_in_ready_stalled", in_ready, 0);
    tick();
    check_eq("bp_occ_single", occupancy, 1);
    check_eq("bp_rd_hold", out_rd, 3);
    tick();
    check_eq("bp_rd_stable", out_rd, 3);
    check_eq("bp_wdata_stable", out_wdata, 32'h33);
    out_ready = 1'b1;
    #1;
    check_eq("bp_in_ready_comb", in_ready, 1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    check_eq("bp_second_rd", out_rd, 4);
    check_eq("bp_second_valid", out_valid, 1);
    check_eq("bp_second_occ", occupancy, 1);
`endif
    tick();
    check_eq("bp_drained_valid", out_valid, 0);
    check_eq("bp_drained_occ", occupancy, 0);

    // Write-back mux
    drive(1'b1, 1'b1, 1'b1, 5'd10, 32'hDEAD_BEEF, 32'h1234);
    tick();
    check_eq("mux_memtoreg1", out_wdata, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 1'b1, 5'd11, 32'hDEAD_BEEF, 32'h1234);
    tick();
    check_eq("mux_memtoreg0", out_wdata, 32'h1234);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();

    // Flush with a full stage and a beat on the input
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 5'd7, 32'h0, 32'h77);
    tick();
    drive(1'b1, 1'b0, 1'b1, 5'd8, 32'h0, 32'h88);
    tick();
`ifdef MEM_WB_PIPE_SKID_EN
    check_eq("flush_pre_occ", occupancy, 2);
`else
    check_eq("flush_pre_occ", occupancy, 1);
`endif
    drive(1'b1, 1'b0, 1'b1, 5'd9, 32'h0, 32'h99);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    check_eq("flush_out_valid", out_valid, 0);
    check_eq("flush_occ", occupancy, 0);
    check_eq("flush_regwrite", out_regwrite, 0);
    check_eq("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    check_eq("flush_beat_absent", out_valid, 0);
    check_eq("flush_occ_after", occupancy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
